// File: rtl/dbg_probe_pkg.sv
// Shared definitions for the debug probe scheduler.
//   state_e     : capture FSM state, its 2-bit code is what appears in probe_tag[3:2]
//   PROBE_W     : width of the ILA data probes (probe1..probe15)
//   TAG_W       : width of the ILA tag probe
//   state_code(): state-code field of the tag
package dbg_probe_pkg;

  localparam int PROBE_W = 15;
  localparam int TAG_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ARMED  = 2'd2,
    ST_POST   = 2'd3
  } state_e;

  // The state code is the enum encoding itself; kept as a function so the
  // tag layout has one owner.
  function automatic logic [1:0] state_code(input state_e st);
    return st;
  endfunction

endpackage

// File: rtl/dbg_rr_arb.sv
// Round-robin arbiter for the probe scheduler.
// Picks the first requester at or after the priority pointer, wrapping.
// The pointer moves only when the scheduler finishes or abandons a capture,
// and then lands just past the index that was served.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (pointer -> 0)
//   req         : NSRC request lines
//   adv         : advance the pointer past adv_idx this cycle
//   adv_idx     : index that was just served
//   gnt_valid   : some requester is pending (combinational)
//   gnt_idx     : index that would be granted (combinational)
module dbg_rr_arb #(
  parameter int NSRC = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] req,
  input  logic            adv,
  input  logic [1:0]      adv_idx,
  output logic            gnt_valid,
  output logic [1:0]      gnt_idx
);

  logic [1:0] ptr_q;
  logic [1:0] ptr_d;

  // Next pointer: one past the served index, modulo NSRC.
  always_comb begin
    if (adv) begin
      if ((int'(adv_idx) + 32'sd1) >= NSRC) begin
        ptr_d = 2'd0;
      end else begin
        ptr_d = adv_idx + 2'd1;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Priority search; walking downward lets the candidate nearest the
  // pointer overwrite the others without an early exit.
  always_comb begin
    int cand;
    logic hit;
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      cand      = int'(ptr_q) + i;
      cand      = (cand >= NSRC) ? (cand - NSRC) : cand;
      hit       = |(req & (NSRC'(1'b1) << cand));
      gnt_valid = hit ? 1'b1 : gnt_valid;
      gnt_idx   = hit ? 2'(cand) : gnt_idx;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dbg_probe_sched.sv
// Debug probe scheduler: shares one ILA probe bus between NSRC requesters.
// A granted source goes through SETTLE (mux switched, ILA sees stable data),
// ARMED (waiting for its trigger), POST (post-trigger window), then the
// grant drops and the next requester is chosen round-robin.
//
// Optional feature: define DBG_PROBE_SCHED_TIMEOUT_EN to bound the ARMED
// phase to ARM_TIMEOUT cycles; without it ARMED waits forever and
// src_timeout is constant 0.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   src_req      : per-source capture request (level)
//   src_data     : per-source debug signals, source i at [15*i+14:15*i]
//   src_trig     : per-source trigger condition
//   src_grant    : one-hot grant (level, registered)
//   src_done     : one-cycle pulse when a capture completes
//   src_timeout  : one-cycle pulse when the armed window expires
//   probe_tag    : {state code, granted index}, index 0 in IDLE
//   probe_data   : granted source's data, one cycle late; 0 in IDLE
//   probe_trig   : one-cycle trigger marker aligned with the trigger sample
//   busy         : high in any state other than IDLE
module dbg_probe_sched
  import dbg_probe_pkg::*;
#(
  parameter int NSRC        = 4,
  parameter int SETTLE_LEN  = 8,
  parameter int POST_LEN    = 64,
  parameter int ARM_TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NSRC-1:0]         src_req,
  input  logic [NSRC*PROBE_W-1:0] src_data,
  input  logic [NSRC-1:0]         src_trig,
  output logic [NSRC-1:0]         src_grant,
  output logic [NSRC-1:0]         src_done,
  output logic [NSRC-1:0]         src_timeout,
  output logic [TAG_W-1:0]        probe_tag,
  output logic [PROBE_W-1:0]      probe_data,
  output logic                    probe_trig,
  output logic                    busy
);

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [NSRC-1:0]      grant_q, grant_d;
  logic [NSRC-1:0]      done_q, done_d;
  logic [NSRC-1:0]      timeout_q, timeout_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [PROBE_W-1:0]   data_q, data_d;
  logic                 trig_q, trig_d;
  logic                 busy_q, busy_d;

  logic                 arb_valid_s;
  logic [1:0]           arb_idx_s;
  logic                 adv_s;
  logic                 gnt_req_s;
  logic                 gnt_trig_s;
  logic [PROBE_W-1:0]   sel_data_s;

`ifdef DBG_PROBE_SCHED_TIMEOUT_EN
  logic [15:0]          tcnt_q, tcnt_d;
`else
  logic [15:0]          unused_arm_timeout_s;
  assign unused_arm_timeout_s = 16'(ARM_TIMEOUT);
`endif

  function automatic logic [NSRC-1:0] onehot(input logic [1:0] i);
    return NSRC'(1'b1) << i;
  endfunction

  dbg_rr_arb #(
    .NSRC (NSRC)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (src_req),
    .adv       (adv_s),
    .adv_idx   (idx_q),
    .gnt_valid (arb_valid_s),
    .gnt_idx   (arb_idx_s)
  );

  // grant_q is one-hot on idx_q whenever a capture is active, so masking
  // with it selects the granted source's req/trig without indexing.
  assign gnt_req_s  = |(src_req & grant_q);
  assign gnt_trig_s = |(src_trig & grant_q);

  // Capture sequencer: next state, counters and event pulses.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    done_d    = '0;
    timeout_d = '0;
    trig_d    = 1'b0;
    adv_s     = 1'b0;
`ifdef DBG_PROBE_SCHED_TIMEOUT_EN
    tcnt_d    = tcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          state_d = ST_SETTLE;
          idx_d   = arb_idx_s;
          cnt_d   = 16'(SETTLE_LEN - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!gnt_req_s) begin
          state_d = ST_IDLE;
          adv_s   = 1'b1;
        end else if (cnt_q == 16'd0) begin
          state_d = ST_ARMED;
`ifdef DBG_PROBE_SCHED_TIMEOUT_EN
          tcnt_d  = 16'(ARM_TIMEOUT - 1);
`endif
        end else begin
          cnt_d   = cnt_q - 16'd1;
        end
      end
      ST_ARMED: begin
        // Request drop beats trigger; trigger beats timeout expiry.
        if (!gnt_req_s) begin
          state_d = ST_IDLE;
          adv_s   = 1'b1;
        end else if (gnt_trig_s) begin
          state_d = ST_POST;
          cnt_d   = 16'(POST_LEN - 1);
          trig_d  = 1'b1;
`ifdef DBG_PROBE_SCHED_TIMEOUT_EN
        end else if (tcnt_q == 16'd0) begin
          state_d   = ST_IDLE;
          adv_s     = 1'b1;
          timeout_d = onehot(idx_q);
        end else begin
          tcnt_d    = tcnt_q - 16'd1;
        end
`else
        end else begin
          state_d = ST_ARMED;
        end
`endif
      end
      ST_POST: begin
        // The window always runs to completion once triggered.
        if (cnt_q == 16'd0) begin
          state_d = ST_IDLE;
          adv_s   = 1'b1;
          done_d  = onehot(idx_q);
        end else begin
          cnt_d   = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Probe-bus view of the next state; registering it keeps the tag, grant
  // and data in step with state_q.
  always_comb begin
    sel_data_s = PROBE_W'(src_data >> (PROBE_W * int'(idx_d)));
    if (state_d == ST_IDLE) begin
      grant_d = '0;
      data_d  = '0;
      tag_d   = {state_code(state_d), 2'd0};
      busy_d  = 1'b0;
    end else begin
      grant_d = onehot(idx_d);
      data_d  = sel_data_s;
      tag_d   = {state_code(state_d), idx_d};
      busy_d  = 1'b1;
    end
  end

  // All sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      cnt_q     <= 16'd0;
      grant_q   <= '0;
      done_q    <= '0;
      timeout_q <= '0;
      tag_q     <= '0;
      data_q    <= '0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef DBG_PROBE_SCHED_TIMEOUT_EN
      tcnt_q    <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      trig_q    <= trig_d;
      busy_q    <= busy_d;
`ifdef DBG_PROBE_SCHED_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
`endif
    end
  end

  assign src_grant   = grant_q;
  assign src_done    = done_q;
  assign src_timeout = timeout_q;
  assign probe_tag   = tag_q;
  assign probe_data  = data_q;
  assign probe_trig  = trig_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dbg_probe_sched.sv
// Directed bench for dbg_probe_sched (NSRC=4, SETTLE_LEN=8, POST_LEN=64,
// ARM_TIMEOUT=16). Inputs change and outputs are sampled on the falling
// edge. Cycle cN below is the clock period following the N-th rising edge
// after the stimulus was applied at c0.
module tb_dbg_probe_sched;

  localparam int NSRC = 4;

  logic                clk;
  logic                rst_n;
  logic [NSRC-1:0]     src_req;
  logic [NSRC*15-1:0]  src_data;
  logic [NSRC-1:0]     src_trig;
  logic [NSRC-1:0]     src_grant;
  logic [NSRC-1:0]     src_done;
  logic [NSRC-1:0]     src_timeout;
  logic [3:0]          probe_tag;
  logic [14:0]         probe_data;
  logic                probe_trig;
  logic                busy;

  int n_checks;
  int n_fail;

  localparam logic [14:0] D0 = 15'h0A01;
  localparam logic [14:0] D1 = 15'h1B12;
  localparam logic [14:0] D2 = 15'h2C23;
  localparam logic [14:0] D3 = 15'h3D34;

  dbg_probe_sched #(
    .NSRC        (NSRC),
    .SETTLE_LEN  (8),
    .POST_LEN    (64),
    .ARM_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_req     (src_req),
    .src_data    (src_data),
    .src_trig    (src_trig),
    .src_grant   (src_grant),
    .src_done    (src_done),
    .src_timeout (src_timeout),
    .probe_tag   (probe_tag),
    .probe_data  (probe_data),
    .probe_trig  (probe_trig),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int        bad;
    int        n_gnt;
    int        idle_run;
    int        first_cyc;
    logic [3:0] prev_g;
    logic [3:0] gnt_seq [5];
    logic [1:0] tag_seq [5];
    int        gap_seq [5];
    int        exp_idx [5];
    logic [3:0] exp_oh;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    src_req  = 4'b0000;
    src_trig = 4'b0000;
    src_data = {D3, D2, D1, D0};

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(src_grant), 32'h0);
    chk("rst_tag",   32'(probe_tag), 32'h0);
    chk("rst_data",  32'(probe_data), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    rst_n = 1'b1;

    // ---------------- single request, source 2 ----------------
    @(negedge clk); src_req = 4'b0100;                         // c0
    @(negedge clk);                                            // c1
    chk("t1_grant",  32'(src_grant), 32'h4);
    chk("t1_tag_settle", 32'(probe_tag), 32'h6);
    chk("t1_busy",   32'(busy), 32'h1);
    chk("t1_data",   32'(probe_data), 32'(D2));
    repeat (7) @(negedge clk);                                 // c8
    chk("t1_settle_end", 32'(probe_tag), 32'h6);
    @(negedge clk);                                            // c9
    chk("t1_armed",  32'(probe_tag), 32'hA);
    repeat (11) @(negedge clk);                                // c20
    src_data[44:30] = 15'h5A5A;
    src_trig = 4'b0100;
    @(negedge clk);                                            // c21
    src_trig = 4'b0000;
    src_data = {D3, D2, D1, D0};
    chk("t1_ptrig",  32'(probe_trig), 32'h1);
    chk("t1_trig_sample", 32'(probe_data), 32'h5A5A);
    chk("t1_tag_post", 32'(probe_tag), 32'hE);
    bad = 0;
    for (int k = 22; k <= 84; k++) begin
      @(negedge clk);
      if (probe_trig !== 1'b0 || src_done !== 4'b0000 || src_timeout !== 4'b0000 ||
          probe_tag[1:0] !== 2'd2 || src_grant !== 4'b0100) bad++;
    end
    chk("t1_post_window", 32'(bad), 32'h0);
    @(negedge clk);                                            // c85
    chk("t1_done",   32'(src_done), 32'h4);
    chk("t1_idle_grant", 32'(src_grant), 32'h0);
    chk("t1_idle_tag",   32'(probe_tag), 32'h0);
    chk("t1_idle_data",  32'(probe_data), 32'h0);
    src_req = 4'b0000;
    @(negedge clk);                                            // c86
    chk("t1_done_pulse", 32'(src_done), 32'h0);

    // ---------------- req drop in POST, source 0 (pointer at 3) ----------------
    @(negedge clk); src_req = 4'b0001; src_trig = 4'b0001;     // c0
    @(negedge clk);                                            // c1
    chk("t3_grant", 32'(src_grant), 32'h1);
    repeat (9) @(negedge clk);                                 // c10
    chk("t3_ptrig", 32'(probe_trig), 32'h1);
    chk("t3_tag_post", 32'(probe_tag), 32'hC);
    src_trig = 4'b0000;
    repeat (5) @(negedge clk);                                 // c15
    src_req = 4'b0000;
    repeat (58) @(negedge clk);                                // c73
    chk("t3_still_post", 32'(probe_tag), 32'hC);
    chk("t3_no_early_done", 32'(src_done), 32'h0);
    @(negedge clk);                                            // c74
    chk("t3_done", 32'(src_done), 32'h1);
    chk("t3_busy", 32'(busy), 32'h0);

    // ---------------- abort in ARMED, source 1 (pointer at 1) ----------------
    @(negedge clk); src_req = 4'b0110;                         // c0
    @(negedge clk);                                            // c1
    chk("t4_grant1", 32'(src_grant), 32'h2);
    repeat (11) @(negedge clk);                                // c12
    chk("t4_armed", 32'(probe_tag), 32'h9);
    src_req = 4'b0100;
    @(negedge clk);                                            // c13
    chk("t4_abort_grant", 32'(src_grant), 32'h0);
    chk("t4_abort_busy",  32'(busy), 32'h0);
    chk("t4_abort_nodone", 32'(src_done), 32'h0);
    src_req = 4'b0110;
    @(negedge clk);                                            // c14
    chk("t4_next_grant2", 32'(src_grant), 32'h4);
    chk("t4_nodone", 32'(src_done), 32'h0);
    src_req = 4'b0000;
    @(negedge clk);                                            // c15
    chk("t4_abort2_busy", 32'(busy), 32'h0);

    // ---------------- async reset mid-POST, source 3 (pointer at 3) ----------------
    @(negedge clk); src_req = 4'b1000; src_trig = 4'b1000;     // c0
    @(negedge clk);                                            // c1
    chk("t5_grant3", 32'(src_grant), 32'h8);
    repeat (14) @(negedge clk);                                // c15
    chk("t5_in_post", 32'(probe_tag), 32'hF);
    src_req  = 4'b1111;
    src_trig = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", 32'(src_grant), 32'h0);
    chk("t5_rst_done",  32'(src_done), 32'h0);
    chk("t5_rst_tout",  32'(src_timeout), 32'h0);
    chk("t5_rst_tag",   32'(probe_tag), 32'h0);
    chk("t5_rst_data",  32'(probe_data), 32'h0);
    chk("t5_rst_ptrig", 32'(probe_trig), 32'h0);
    chk("t5_rst_busy",  32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    chk("t5_rst_held", 32'(busy), 32'h0);
    rst_n = 1'b1;

    // ---------------- contention: all four requesting, trigger held ----------------
    n_gnt     = 0;
    idle_run  = 0;
    first_cyc = -1;
    prev_g    = 4'b0000;
    for (int cyc = 0; cyc < 400 && n_gnt < 5; cyc++) begin
      @(negedge clk);
      if (src_grant != 4'b0000 && prev_g == 4'b0000) begin
        if (n_gnt == 0) first_cyc = cyc;
        gnt_seq[n_gnt] = src_grant;
        tag_seq[n_gnt] = probe_tag[1:0];
        gap_seq[n_gnt] = idle_run;
        n_gnt++;
      end
      idle_run = (src_grant == 4'b0000) ? idle_run + 1 : 0;
      prev_g   = src_grant;
    end
    src_req  = 4'b0000;
    src_trig = 4'b0000;
    chk("t6_grant_count", 32'(n_gnt), 32'h5);
    chk("t6_first_latency", 32'(first_cyc), 32'h0);
    exp_idx = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      if (k < n_gnt) begin
        exp_oh = 4'b0001 << exp_idx[k];
        chk($sformatf("t6_grant_%0d", k), 32'(gnt_seq[k]), 32'(exp_oh));
        chk($sformatf("t6_tagidx_%0d", k), 32'(tag_seq[k]), 32'(exp_idx[k]));
        if (k > 0) chk($sformatf("t6_gap_%0d", k), 32'(gap_seq[k]), 32'h1);
      end
    end
    repeat (3) @(negedge clk);
    chk("t6_idle_after", 32'(busy), 32'h0);

`ifdef DBG_PROBE_SCHED_TIMEOUT_EN
    // ---------------- armed timeout, source 1 (pointer at 1) ----------------
    @(negedge clk); src_req = 4'b0010;                         // c0
    @(negedge clk);                                            // c1
    chk("t7_grant", 32'(src_grant), 32'h2);
    repeat (8) @(negedge clk);                                 // c9
    chk("t7_armed", 32'(probe_tag), 32'h9);
    repeat (15) @(negedge clk);                                // c24
    chk("t7_last_armed", 32'(probe_tag), 32'h9);
    chk("t7_no_early_tout", 32'(src_timeout), 32'h0);
    @(negedge clk);                                            // c25
    chk("t7_timeout", 32'(src_timeout), 32'h2);
    chk("t7_grant_drop", 32'(src_grant), 32'h0);
    chk("t7_no_done", 32'(src_done), 32'h0);
    src_req = 4'b0000;
    @(negedge clk);                                            // c26
    chk("t7_tout_pulse", 32'(src_timeout), 32'h0);

    // ---------------- trigger on expiry cycle, source 2 (pointer at 2) ----------------
    @(negedge clk); src_req = 4'b0100;                         // c0
    repeat (24) @(negedge clk);                                // c24
    chk("t8_armed", 32'(probe_tag), 32'hA);
    src_trig = 4'b0100;
    @(negedge clk);                                            // c25
    src_trig = 4'b0000;
    chk("t8_no_tout", 32'(src_timeout), 32'h0);
    chk("t8_ptrig", 32'(probe_trig), 32'h1);
    chk("t8_post", 32'(probe_tag), 32'hE);
    repeat (64) @(negedge clk);                                // c89
    chk("t8_done", 32'(src_done), 32'h4);
    src_req = 4'b0000;
`else
    // ---------------- no timeout: ARMED holds well past ARM_TIMEOUT ----------------
    @(negedge clk); src_req = 4'b0010;                         // c0
    repeat (49) @(negedge clk);                                // c49
    chk("t7_still_armed", 32'(probe_tag), 32'h9);
    chk("t7_tout_tied", 32'(src_timeout), 32'h0);
    src_req = 4'b0000;
    @(negedge clk);
    chk("t7_abort", 32'(busy), 32'h0);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
